// File: rtl/caravel_uart_selftest_if.sv
// Pad-side bundle of the UART self-test engine.
//   mprj_io_out : 38-bit pad output values
//   mprj_io_oeb : 38-bit pad output enables, active low
//   busy        : high while the checkpoint/transmit sequence is running
// master = engine (drives), slave = observer (bench, pad ring).
interface caravel_uart_selftest_if;
    logic [37:0] mprj_io_out;
    logic [37:0] mprj_io_oeb;
    logic        busy;

    modport master (output mprj_io_out, output mprj_io_oeb, output busy);
    modport slave  (input  mprj_io_out, input  mprj_io_oeb, input  busy);
endinterface

// File: rtl/caravel_uart_selftest.sv
// UART self-test engine for the Caravel user-IO ring.
// After reset it waits START_DELAY cycles, raises checkpoint 0xA000 on
// mprj_io[31:16], sends MESSAGE as back-to-back 8N1 frames on mprj_io[6]
// (leftmost character first), then raises checkpoint 0xAB00 and idles.
// Ports:
//   core_clk  : system clock, rising edge
//   core_rstn : asynchronous active-low reset
//   pads      : mprj_io_out / mprj_io_oeb / busy (master modport)
module caravel_uart_selftest #(
    parameter int                   CLKS_PER_BIT = 347,
    parameter int                   START_DELAY  = 2000,
    parameter int                   MSG_LEN      = 26,
    parameter logic [8*MSG_LEN-1:0] MESSAGE      = "Monitor: Test UART passed\n"
) (
    input  logic                    core_clk,
    input  logic                    core_rstn,
    caravel_uart_selftest_if.master pads
);
    localparam int TMR_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int WAIT_W = $clog2(START_DELAY + 1);
    localparam int IDX_W  = 6;

    localparam logic [15:0] CHK_START = 16'hA000;
    localparam logic [15:0] CHK_PASS  = 16'hAB00;

    typedef enum logic [2:0] {WAIT, START, DATA, STOP, NEXT, DONE} state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [TMR_W-1:0]   bit_tmr_q, bit_tmr_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               ser_tx_q, ser_tx_d;
    logic [15:0]        chk_q, chk_d;

    logic               bit_wrap;
    logic               last_byte;

    // Message unpacked into a full 64-entry table so the 6-bit index never
    // runs off the end; entries past MSG_LEN are never selected.
    logic [7:0] msg_mem [64];
    for (genvar g = 0; g < 64; g++) begin : g_msg
        if (g < MSG_LEN) begin : g_used
            assign msg_mem[g] = MESSAGE[8*(MSG_LEN-1-g) +: 8];
        end else begin : g_pad
            assign msg_mem[g] = 8'h00;
        end
    end

    assign bit_wrap  = (bit_tmr_q == TMR_W'(CLKS_PER_BIT - 1));
    assign last_byte = (idx_q == IDX_W'(MSG_LEN - 1));

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state_q    <= WAIT;
            wait_cnt_q <= '0;
            bit_tmr_q  <= '0;
            bit_cnt_q  <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            ser_tx_q   <= 1'b1;
            chk_q      <= 16'h0000;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bit_tmr_q  <= bit_tmr_d;
            bit_cnt_q  <= bit_cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            ser_tx_q   <= ser_tx_d;
            chk_q      <= chk_d;
        end
    end

    // ser_tx_d is always the level for the bit that begins on this edge, so
    // the pad changes exactly on bit boundaries with no combinational path.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        bit_tmr_d  = bit_tmr_q;
        bit_cnt_d  = bit_cnt_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        ser_tx_d   = ser_tx_q;
        chk_d      = chk_q;

        if (state_q == START || state_q == DATA || state_q == STOP) begin
            bit_tmr_d = bit_wrap ? '0 : bit_tmr_q + TMR_W'(1);
        end

        case (state_q)
            WAIT: begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                if (wait_cnt_q == WAIT_W'(START_DELAY - 1)) begin
                    chk_d    = CHK_START;
                    idx_d    = '0;
                    shreg_d  = msg_mem[0];
                    ser_tx_d = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_wrap) begin
                    ser_tx_d  = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_wrap) begin
                    if (bit_cnt_q == 3'd7) begin
                        ser_tx_d = 1'b1;
                        state_d  = STOP;
                    end else begin
                        ser_tx_d  = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // The NEXT decision is taken on the stop-bit wrap itself so the
                // following start bit begins with no idle gap.
                if (bit_wrap) begin
                    if (last_byte) begin
                        chk_d   = CHK_PASS;
                        state_d = DONE;
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        shreg_d  = msg_mem[idx_q + IDX_W'(1)];
                        ser_tx_d = 1'b0;
                        state_d  = START;
                    end
                end
            end
            NEXT: begin
                // Never held across an edge; parks safely if ever reached.
                ser_tx_d = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                ser_tx_d = 1'b1;
            end
            default: state_d = WAIT;
        endcase
    end

    assign pads.mprj_io_out = {6'b0, chk_q, 9'b0, ser_tx_q, 6'b0};
    assign pads.mprj_io_oeb = {6'h3F, 16'h0000, 9'h1FF, 1'b0, 6'h3F};
    assign pads.busy        = (state_q != DONE);

endmodule

// File: tb/tb_caravel_uart_selftest.sv
module tb_caravel_uart_selftest;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn_def, rstn_fast, rstn_small;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   sel   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    caravel_uart_selftest_if if_def ();
    caravel_uart_selftest_if if_fast ();
    caravel_uart_selftest_if if_small ();

    // Default parameters: reset, start checkpoint and 347-cycle bit timing.
    caravel_uart_selftest u_def (
        .core_clk(clk), .core_rstn(rstn_def), .pads(if_def));

    // Shorter bit time so the whole message plus a restart fits the run.
    caravel_uart_selftest #(.CLKS_PER_BIT(32)) u_fast (
        .core_clk(clk), .core_rstn(rstn_fast), .pads(if_fast));

    caravel_uart_selftest #(.CLKS_PER_BIT(4), .START_DELAY(5), .MSG_LEN(1),
                            .MESSAGE("A")) u_small (
        .core_clk(clk), .core_rstn(rstn_small), .pads(if_small));

    logic        tx, busy;
    logic [15:0] cb;
    logic [37:0] oeb, out;

    always_comb begin
        tx = 1'b1; cb = '0; busy = 1'b0; oeb = '0; out = '0;
        case (sel)
            0: begin out = if_def.mprj_io_out; oeb = if_def.mprj_io_oeb; busy = if_def.busy; end
            1: begin out = if_fast.mprj_io_out; oeb = if_fast.mprj_io_oeb; busy = if_fast.busy; end
            default: begin out = if_small.mprj_io_out; oeb = if_small.mprj_io_oeb; busy = if_small.busy; end
        endcase
        tx = out[6];
        cb = out[31:16];
    end

    string msg = "Monitor: Test UART passed\n";

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Samples each cycle until the line falls; k = cycles since call.
    task automatic find_start(input int limit, output int k, output logic [15:0] cb_before);
        k = 0;
        cb_before = cb;
        do begin
            cb_before = cb;
            @(negedge clk);
            k++;
        end while (tx === 1'b1 && k < limit);
    endtask

    // Entered on the sample right after a start edge; leaves exactly one
    // frame later, which is where the next start edge must be.
    task automatic rx_byte(input int c, output logic [7:0] b, output bit frame_ok,
                           output logic [15:0] cb_stop);
        b = '0;
        wait_cyc(c / 2);
        frame_ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
            wait_cyc(c);
            b[i] = tx;
        end
        wait_cyc(c);
        frame_ok = frame_ok && (tx === 1'b1);
        cb_stop  = cb;
        wait_cyc(c - c / 2);
    endtask

    task automatic test_reset;
        sel = 0;
        rstn_def = 1'b0;
        wait_cyc(40);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
        total++; if (cb !== 16'h0000) begin bad++; $display("FAIL reset_chk got=%h want=0000", cb); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b want=1", busy); end
        total++; if (oeb[6] !== 1'b0) begin bad++; $display("FAIL reset_oeb6 got=%b want=0", oeb[6]); end
        total++; if (oeb[3] !== 1'b1) begin bad++; $display("FAIL reset_oeb3 got=%b want=1", oeb[3]); end
        total++; if (oeb !== 38'h3F0000FFBF) begin bad++; $display("FAIL reset_oeb got=%h want=3f0000ffbf", oeb); end
        total++; if (out !== 38'h0000000040) begin bad++; $display("FAIL reset_out got=%h want=0000000040", out); end
    endtask

    task automatic test_start_checkpoint;
        int k; logic [15:0] cbb;
        rstn_def = 1'b1;
        find_start(2100, k, cbb);
        total++; if (k !== 2000) begin bad++; $display("FAIL start_delay got=%0d want=2000", k); end
        total++; if (cb !== 16'hA000) begin bad++; $display("FAIL start_chk got=%h want=a000", cb); end
        total++; if (cbb !== 16'h0000) begin bad++; $display("FAIL start_chk_before got=%h want=0000", cbb); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%b want=1", busy); end
    endtask

    task automatic test_serial_decode;
        logic [7:0] b; bit ok; logic [15:0] cs;
        rx_byte(347, b, ok, cs);
        total++; if (b !== 8'h4D) begin bad++; $display("FAIL rx347_byte0 got=%h want=4d", b); end
        total++; if (!ok) begin bad++; $display("FAIL rx347_frame0 got=framing_error want=ok"); end
        rx_byte(347, b, ok, cs);
        total++; if (b !== 8'h6F) begin bad++; $display("FAIL rx347_byte1 got=%h want=6f", b); end
        total++; if (!ok) begin bad++; $display("FAIL rx347_frame1 got=framing_error want=ok"); end
        rstn_def = 1'b0;
    endtask

    task automatic test_full_message;
        int k, rel, errs, ferr; logic [7:0] b; bit ok; logic [15:0] cbb, cs;
        sel = 1;
        rstn_fast = 1'b0;
        wait_cyc(5);
        rstn_fast = 1'b1;
        rel = cyc;
        find_start(2100, k, cbb);
        total++; if (k !== 2000) begin bad++; $display("FAIL fast_start got=%0d want=2000", k); end
        ferr = 0;
        for (int i = 0; i < 26; i++) begin
            rx_byte(32, b, ok, cs);
            if (!ok) ferr++;
            total++;
            if (b !== msg[i]) begin bad++; $display("FAIL msg_byte%0d got=%h want=%h", i, b, msg[i]); end
        end
        total++; if (ferr != 0) begin bad++; $display("FAIL framing got=%0d errors want=0", ferr); end
        total++; if (cs !== 16'hA000) begin bad++; $display("FAIL last_stop_chk got=%h want=a000", cs); end
        total++; if (cyc - rel !== 10320) begin bad++; $display("FAIL pass_cycle got=%0d want=10320", cyc - rel); end
        total++; if (cb !== 16'hAB00) begin bad++; $display("FAIL pass_chk got=%h want=ab00", cb); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL pass_busy got=%b want=0", busy); end
        errs = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || cb !== 16'hAB00 || busy !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL done_hold got=%0d bad cycles want=0", errs); end
    endtask

    task automatic test_midframe_reset;
        int k; logic [7:0] b; bit ok; logic [15:0] cbb, cs;
        sel = 1;
        rstn_fast = 1'b0;
        wait_cyc(3);
        rstn_fast = 1'b1;
        find_start(2100, k, cbb);
        for (int i = 0; i < 3; i++) rx_byte(32, b, ok, cs);
        wait_cyc(100);
        // 'i' = 0x69: data bit 2 is low 100 cycles into the frame
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL mid_pre_tx got=%b want=0", tx); end
        #2 rstn_fast = 1'b0;
        #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL mid_async_tx got=%b want=1", tx); end
        total++; if (cb !== 16'h0000) begin bad++; $display("FAIL mid_async_chk got=%h want=0000", cb); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_async_busy got=%b want=1", busy); end
        wait_cyc(20);
        rstn_fast = 1'b1;
        find_start(2100, k, cbb);
        total++; if (k !== 2000) begin bad++; $display("FAIL mid_restart got=%0d want=2000", k); end
        total++; if (cbb !== 16'h0000) begin bad++; $display("FAIL mid_restart_chk_before got=%h want=0000", cbb); end
        rx_byte(32, b, ok, cs);
        total++; if (b !== 8'h4D || !ok) begin bad++; $display("FAIL mid_restart_byte0 got=%h ok=%0d want=4d ok=1", b, ok); end
        rstn_fast = 1'b0;
    endtask

    task automatic test_param_override;
        logic [9:0]  w;
        logic        etx, ebusy;
        logic [15:0] ecb;
        sel = 2;
        w = {1'b1, 8'h41, 1'b0};
        rstn_small = 1'b0;
        wait_cyc(3);
        rstn_small = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k < 5) begin
                etx = 1'b1; ecb = 16'h0000; ebusy = 1'b1;
            end else if (k < 45) begin
                etx = w[(k - 5) / 4]; ecb = 16'hA000; ebusy = 1'b1;
            end else begin
                etx = 1'b1; ecb = 16'hAB00; ebusy = 1'b0;
            end
            total++;
            if (tx !== etx || cb !== ecb || busy !== ebusy) begin
                bad++;
                $display("FAIL ovr_cycle%0d got tx=%b chk=%h busy=%b want tx=%b chk=%h busy=%b",
                         k, tx, cb, busy, etx, ecb, ebusy);
            end
        end
    endtask

    initial begin
        rstn_def = 1'b0; rstn_fast = 1'b0; rstn_small = 1'b0;
        test_reset;
        test_start_checkpoint;
        test_serial_decode;
        test_full_message;
        test_midframe_reset;
        test_param_override;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
